// File: rtl/fu_product_accum.sv
`default_nettype none
// ============================================================================
//  Module      : fu_product_accum
//  Description : Unpacks the packed gated_fu product word into 1/2/4 unsigned
//                lanes, accumulates each lane over a group of beats with
//                per-lane saturation, and presents the per-lane sums
//                downstream through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_product_accum #(
    parameter int ACC_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          p_in,
    input  logic [1:0]           mode_in,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   acc_out,
    output logic [1:0]           out_mode,
    output logic [3:0]           sat,
    output logic                 err_mode
);

    localparam logic [1:0] c_MODE_8X8 = 2'b00;
    localparam logic [1:0] c_MODE_4X4 = 2'b01;
    localparam logic [1:0] c_MODE_2X2 = 2'b10;
    localparam logic [1:0] c_MODE_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_mode;
    logic [ACC_W-1:0]   r_acc [4];
    logic [3:0]         r_sat;
    logic               r_err;

    logic               w_xfer;
    logic [1:0]         w_mode_sel;
    logic [15:0]        w_lane [4];
    logic [ACC_W:0]     w_sum  [4];

    // The first beat of a group is decoded with the incoming mode; later
    // beats use the mode latched at the start of the group.
    assign w_mode_sel = (r_state == S_IDLE) ? mode_in : r_mode;

    // Split the packed product into unsigned lanes; reserved mode yields zeros.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_lane[i] = 16'd0;
        end
        case (w_mode_sel)
            c_MODE_8X8: begin
                w_lane[0] = p_in;
            end
            c_MODE_4X4: begin
                w_lane[0] = {8'd0, p_in[7:0]};
                w_lane[1] = {8'd0, p_in[15:8]};
            end
            c_MODE_2X2: begin
                for (int i = 0; i < 4; i++) begin
                    w_lane[i] = {12'd0, p_in[4*i +: 4]};
                end
            end
            default: begin
            end
        endcase
    end

    // One extra bit per lane captures the carry that signals overflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sum[i] = {1'b0, r_acc[i]} + (ACC_W+1)'(w_lane[i]);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE, S_ACCUM: begin
                in_ready = 1'b1;
                w_xfer   = in_valid;
                if (in_valid) begin
                    w_state_nxt = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Accumulator datapath: load on the first beat, saturating add afterwards,
    // clear once the result has been handed off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 2'b00;
            r_sat  <= 4'b0000;
            r_err  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_mode <= mode_in;
                        r_sat  <= 4'b0000;
                        if (mode_in == c_MODE_RSV) begin
                            r_err <= 1'b1;
                        end
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= ACC_W'(w_lane[i]);
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_xfer) begin
                        for (int i = 0; i < 4; i++) begin
                            if (r_sat[i] || w_sum[i][ACC_W]) begin
                                r_acc[i] <= '1;
                                r_sat[i] <= 1'b1;
                            end else begin
                                r_acc[i] <= w_sum[i][ACC_W-1:0];
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_sat <= 4'b0000;
                        for (int i = 0; i < 4; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result fields read zero unless a completed group is being presented.
    always_comb begin
        acc_out  = '0;
        out_mode = 2'b00;
        sat      = 4'b0000;
        if (out_valid) begin
            out_mode = r_mode;
            sat      = r_sat;
            for (int i = 0; i < 4; i++) begin
                acc_out[i*ACC_W +: ACC_W] = r_acc[i];
            end
        end
    end

    assign err_mode = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fu_product_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_product_accum
//  Description : Self-checking bench for fu_product_accum; a 24-bit and a
//                16-bit instance share stimulus and are compared against a
//                plain-arithmetic group-sum reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_product_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] p_in;
    logic [1:0]  mode_in;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_err;
    logic [95:0] a_acc;
    logic [1:0]  a_mode;
    logic [3:0]  a_sat;

    logic        b_in_ready, b_out_valid, b_err;
    logic [63:0] b_acc;
    logic [1:0]  b_mode;
    logic [3:0]  b_sat;

    int          n_tests = 0;
    int          n_fail  = 0;

    logic [15:0] gq[$];
    logic [95:0] e_acc;
    logic [3:0]  e_sat;
    logic [95:0] e16_acc;
    logic [3:0]  e16_sat;

    fu_product_accum #(.ACC_W(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .p_in(p_in), .mode_in(mode_in), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .acc_out(a_acc),
        .out_mode(a_mode), .sat(a_sat), .err_mode(a_err)
    );

    fu_product_accum #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .p_in(p_in), .mode_in(mode_in), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .acc_out(b_acc),
        .out_mode(b_mode), .sat(b_sat), .err_mode(b_err)
    );

    always #5 clk = ~clk;

    // Reference: total each lane of the whole group with wide integers, then
    // clamp at the end (sums only grow, so final overflow == any overflow).
    function automatic void model(input int w, input logic [1:0] m,
                                  output logic [95:0] acc, output logic [3:0] s);
        longint sum[4];
        longint mx;
        longint p;
        mx = (longint'(1) << w) - 1;
        for (int i = 0; i < 4; i++) sum[i] = 0;
        foreach (gq[k]) begin
            p = longint'(gq[k]);
            case (m)
                2'b00: sum[0] += p;
                2'b01: begin sum[0] += p % 256; sum[1] += p / 256; end
                2'b10: for (int i = 0; i < 4; i++) sum[i] += (p >> (4*i)) % 16;
                default: ;
            endcase
        end
        acc = '0;
        s   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (sum[i] > mx) begin
                s[i]   = 1'b1;
                sum[i] = mx;
            end
            acc = acc | (96'(sum[i]) << (i*w));
        end
    endfunction

    // Drive every beat in gq; later beats carry a different mode_in, which
    // the DUT must ignore. Optional idle gaps carry random junk.
    task automatic drive_beats(input logic [1:0] m, input int gap_max);
        int g;
        for (int i = 0; i < gq.size(); i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                p_in     = 16'($urandom);
                mode_in  = 2'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            p_in     = gq[i];
            mode_in  = (i == 0) ? m : (m ^ 2'b10);
            in_last  = (i == gq.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_acc !== 96'd0 || a_mode !== 2'b00 ||
            a_sat !== 4'b0000 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b acc=%h mode=%b sat=%b err=%b, want all zero",
                     a_out_valid, a_acc, a_mode, a_sat, a_err);
        end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
        end
    endtask

    task automatic test_mode01();
        gq = '{16'h0203, 16'h0203, 16'h0203};
        drive_beats(2'b01, 0);
        model(24, 2'b01, e_acc, e_sat);
        n_tests++;
        if (a_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL m01_latency: out_valid=%b want 1", a_out_valid);
        end
        n_tests++;
        if (a_acc !== e_acc || a_acc[23:0] !== 24'd9 || a_acc[47:24] !== 24'd6) begin
            n_fail++;
            $display("FAIL m01_acc: got %h want %h", a_acc, e_acc);
        end
        n_tests++;
        if (a_sat !== 4'b0000 || a_mode !== 2'b01) begin
            n_fail++;
            $display("FAIL m01_sat_mode: sat=%b mode=%b want 0000/01", a_sat, a_mode);
        end
        release_out();
        n_tests++;
        if (a_out_valid !== 1'b0 || a_acc !== 96'd0) begin
            n_fail++;
            $display("FAIL m01_release: valid=%b acc=%h want 0/0", a_out_valid, a_acc);
        end
    endtask

    task automatic test_mode00();
        gq = '{16'h002D, 16'hFE01};
        drive_beats(2'b00, 1);
        model(24, 2'b00, e_acc, e_sat);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_acc !== e_acc || a_acc[23:0] !== 24'd65070 ||
            a_mode !== 2'b00) begin
            n_fail++;
            $display("FAIL m00_acc: valid=%b acc=%h mode=%b want 1/%h/00",
                     a_out_valid, a_acc, a_mode, e_acc);
        end
        release_out();
    endtask

    task automatic test_mode10();
        gq = '{16'h9421, 16'h9421};
        drive_beats(2'b10, 0);
        model(24, 2'b10, e_acc, e_sat);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_acc !== e_acc ||
            a_acc !== {24'd18, 24'd8, 24'd4, 24'd2}) begin
            n_fail++;
            $display("FAIL m10_acc: valid=%b acc=%h want %h", a_out_valid, a_acc, e_acc);
        end
        n_tests++;
        if (a_mode !== 2'b10) begin
            n_fail++;
            $display("FAIL m10_mode: got %b want 10", a_mode);
        end
        release_out();
    endtask

    task automatic test_saturation();
        gq = '{16'hFE01, 16'hFE01};
        drive_beats(2'b00, 0);
        model(16, 2'b00, e16_acc, e16_sat);
        model(24, 2'b00, e_acc, e_sat);
        n_tests++;
        if (b_acc !== e16_acc[63:0] || b_acc[15:0] !== 16'hFFFF || b_sat !== 4'b0001) begin
            n_fail++;
            $display("FAIL sat16: acc=%h sat=%b want %h/0001", b_acc, b_sat, e16_acc[63:0]);
        end
        n_tests++;
        if (a_acc !== e_acc || a_sat !== 4'b0000) begin
            n_fail++;
            $display("FAIL nosat24: acc=%h sat=%b want %h/0000", a_acc, a_sat, e_acc);
        end
        release_out();
        gq = '{16'h0001};
        drive_beats(2'b00, 0);
        n_tests++;
        if (b_out_valid !== 1'b1 || b_acc !== 64'd1 || b_sat !== 4'b0000) begin
            n_fail++;
            $display("FAIL sat16_clear: valid=%b acc=%h sat=%b want 1/1/0000",
                     b_out_valid, b_acc, b_sat);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        gq = '{16'h1234, 16'h0101};
        drive_beats(2'b01, 0);
        model(24, 2'b01, e_acc, e_sat);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_acc !== e_acc ||
                a_mode !== 2'b01 || a_sat !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b rdy=%b acc=%h mode=%b want 1/0/%h/01",
                         c, a_out_valid, a_in_ready, a_acc, a_mode, e_acc);
            end
            in_valid = 1'b1;
            p_in     = 16'($urandom);
            mode_in  = 2'b00;
            in_last  = 1'b1;
            @(posedge clk); #1;
        end
        release_out();
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b want 0", a_out_valid);
        end
        gq = '{16'h0005};
        drive_beats(2'b00, 0);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_acc !== 96'd5) begin
            n_fail++;
            $display("FAIL bp_ignored_beats: valid=%b acc=%h want 1/5", a_out_valid, a_acc);
        end
        release_out();
    endtask

    task automatic test_reset_mid_group();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            p_in     = 16'h0404;
            mode_in  = 2'b01;
            in_last  = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_acc !== 96'd0 || a_mode !== 2'b00 ||
            a_sat !== 4'b0000 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: valid=%b acc=%h mode=%b sat=%b err=%b want zeros",
                     a_out_valid, a_acc, a_mode, a_sat, a_err);
        end
        gq = '{16'hFFFF};
        drive_beats(2'b11, 0);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_acc !== 96'd0 || a_mode !== 2'b11 || a_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_group: valid=%b acc=%h mode=%b err=%b want 1/0/11/1",
                     a_out_valid, a_acc, a_mode, a_err);
        end
        release_out();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (a_err !== 1'b1 || a_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_sticky: err=%b valid=%b want 1/0", a_err, a_out_valid);
        end
    endtask

    task automatic test_random_groups();
        logic [1:0] m;
        int         n;
        int         d;
        for (int g = 0; g < 40; g++) begin
            m = ($urandom_range(9, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
            n = $urandom_range(6, 1);
            gq.delete();
            for (int k = 0; k < n; k++) gq.push_back(16'($urandom));
            drive_beats(m, 2);
            model(24, m, e_acc, e_sat);
            model(16, m, e16_acc, e16_sat);
            n_tests++;
            if (a_out_valid !== 1'b1 || a_acc !== e_acc || a_sat !== e_sat || a_mode !== m) begin
                n_fail++;
                $display("FAIL rand24[%0d]: valid=%b acc=%h sat=%b mode=%b want 1/%h/%b/%b",
                         g, a_out_valid, a_acc, a_sat, a_mode, e_acc, e_sat, m);
            end
            n_tests++;
            if (b_out_valid !== 1'b1 || b_acc !== e16_acc[63:0] || b_sat !== e16_sat) begin
                n_fail++;
                $display("FAIL rand16[%0d]: valid=%b acc=%h sat=%b want 1/%h/%b",
                         g, b_out_valid, b_acc, b_sat, e16_acc[63:0], e16_sat);
            end
            d = $urandom_range(3, 0);
            repeat (d) begin
                @(posedge clk); #1;
                n_tests++;
                if (a_out_valid !== 1'b1 || a_acc !== e_acc) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: valid=%b acc=%h want 1/%h",
                             g, a_out_valid, a_acc, e_acc);
                end
            end
            release_out();
            n_tests++;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_release[%0d]: valid24=%b valid16=%b want 0/0",
                         g, a_out_valid, b_out_valid);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        p_in      = 16'd0;
        mode_in   = 2'b00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_mode01();
        test_mode00();
        test_mode10();
        test_saturation();
        test_backpressure();
        test_reset_mid_group();
        test_random_groups();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
